// File: rtl/adder8_operand_recover.sv
// adder8_operand_recover: bit-serial inverse of the 8-bit carry-in adder.
// Recovers operand b = {cout,s} - a - c, BITS_PER_CYCLE bits per RUN cycle,
// with valid/ready handshakes on the input and output sides.
// Optional feature macro: ADDER8_RECOVER_ERR_EN adds the err output, which flags
// results that do not fit in WIDTH bits (negative, or >= 2^WIDTH).
module adder8_operand_recover #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b
`ifdef ADDER8_RECOVER_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BPC   = BITS_PER_CYCLE;

  if ((BITS_PER_CYCLE == 0) || (WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_cfg
    $error("adder8_operand_recover: BITS_PER_CYCLE must be nonzero and divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] a_q;
  logic             cout_q;
  logic             borrow;
  logic [CNT_W-1:0] count;

  logic [BPC-1:0]   s_chunk;
  logic [BPC-1:0]   a_chunk;
  logic [BPC:0]     chunk_diff;
  logic [BPC-1:0]   chunk_bits;
  logic             chunk_borrow;
  logic [WIDTH-1:0] b_next;

  // Subtract the current LSB chunk; the extra MSB of the difference is the borrow out.
  // s_q/a_q are shifted right each RUN cycle and b fills from the top, so after N
  // cycles chunk k has landed in b[k] exactly as an indexed write would place it.
  always_comb begin
    s_chunk      = s_q[BPC-1:0];
    a_chunk      = a_q[BPC-1:0];
    chunk_diff   = {1'b0, s_chunk} - {1'b0, a_chunk} - {{BPC{1'b0}}, borrow};
    chunk_bits   = chunk_diff[BPC-1:0];
    chunk_borrow = chunk_diff[BPC];
    b_next       = (b >> BPC) | (WIDTH'(chunk_bits) << (WIDTH - BPC));
  end

  // Control FSM and datapath registers with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      b         <= '0;
      borrow    <= 1'b0;
      count     <= '0;
      s_q       <= '0;
      a_q       <= '0;
      cout_q    <= 1'b0;
`ifdef ADDER8_RECOVER_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            s_q      <= s;
            a_q      <= a;
            cout_q   <= cout;
            borrow   <= c;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          s_q    <= s_q >> BPC;
          a_q    <= a_q >> BPC;
          b      <= b_next;
          borrow <= chunk_borrow;
          count  <= count + 1'b1;
          if (count == CNT_W'(N - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef ADDER8_RECOVER_ERR_EN
            err       <= cout_q ^ chunk_borrow;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifndef ADDER8_RECOVER_ERR_EN
  // Without the error feature the latched cout has no consumer.
  logic unused_cout;
  assign unused_cout = cout_q;
`endif

endmodule

// File: tb/tb_adder8_operand_recover.sv
// tb_adder8_operand_recover: directed vector table, handshake/backpressure and
// mid-run reset sequences, plus a randomized sweep checked against a plain
// arithmetic reference of {cout,s} - a - c.
module tb_adder8_operand_recover;

  localparam int unsigned W   = 8;
  localparam int unsigned BPC = 1;
  localparam int unsigned N   = W / BPC;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] s = '0;
  logic         cout = 1'b0;
  logic [W-1:0] a = '0;
  logic         c = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] b;
`ifdef ADDER8_RECOVER_ERR_EN
  logic         err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  adder8_operand_recover #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s        (s),
    .cout     (cout),
    .a        (a),
    .c        (c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .b        (b)
`ifdef ADDER8_RECOVER_ERR_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic [W-1:0] a;
    logic         c;
    logic [W-1:0] exp_b;
    logic         exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] ref_model(input logic [W-1:0] sv, input logic co,
                                          input logic [W-1:0] av, input logic cv);
    int r;
    logic [W:0] res;
    r = int'({co, sv}) - int'(av) - int'(cv);
    res[W-1:0] = r[W-1:0];
    res[W]     = (r < 0) || (r >= (1 << W));
    return res;
  endfunction

  function automatic logic cur_err();
`ifdef ADDER8_RECOVER_ERR_EN
    return err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic send(input logic [W-1:0] sv, input logic co, input logic [W-1:0] av,
                      input logic cv);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    s = sv; cout = co; a = av; c = cv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    s = W'($urandom); a = W'($urandom); cout = 1'($urandom); c = 1'($urandom);
  endtask

  task automatic collect(output logic [W-1:0] gb, output logic ge);
    int cyc;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
    end
    check("latency", 32'(cyc), 32'(N));
    gb = b;
    ge = cur_err();
  endtask

  task automatic release_out(input int hold, input logic [W-1:0] gb, input logic ge);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_b", 32'(b), 32'(gb));
      check("hold_in_ready", 32'(in_ready), 32'd0);
`ifdef ADDER8_RECOVER_ERR_EN
      check("hold_err", 32'(err), 32'(ge));
`else
      if (ge) check("hold_err_absent", 32'(ge), 32'd0);
`endif
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drop_valid", 32'(out_valid), 32'd0);
    check("ready_after", 32'(in_ready), 32'd1);
  endtask

  task automatic do_item(input string name, input logic [W-1:0] sv, input logic co,
                         input logic [W-1:0] av, input logic cv,
                         input logic [W-1:0] eb, input logic ee, input int hold);
    logic [W-1:0] gb;
    logic ge;
    send(sv, co, av, cv);
    collect(gb, ge);
    check({name, "_b"}, 32'(gb), 32'(eb));
`ifdef ADDER8_RECOVER_ERR_EN
    check({name, "_err"}, 32'(ge), 32'(ee));
`else
    if (ee !== ee) check({name, "_err"}, 32'(ge), 32'(ee));
`endif
    release_out(hold, gb, ge);
  endtask

  initial begin
    logic [W:0] m;
    logic [W:0] sum;
    logic [W-1:0] rb, rs, ra;
    logic rc, rco;
    int seen_valid;

    vecs[0] = '{s: 8'h46, cout: 1'b0, a: 8'h12, c: 1'b0, exp_b: 8'h34, exp_err: 1'b0};
    vecs[1] = '{s: 8'hFF, cout: 1'b1, a: 8'hFF, c: 1'b1, exp_b: 8'hFF, exp_err: 1'b0};
    vecs[2] = '{s: 8'h00, cout: 1'b0, a: 8'h01, c: 1'b0, exp_b: 8'hFF, exp_err: 1'b1};
    vecs[3] = '{s: 8'h00, cout: 1'b0, a: 8'h00, c: 1'b1, exp_b: 8'hFF, exp_err: 1'b1};
    vecs[4] = '{s: 8'h00, cout: 1'b1, a: 8'h00, c: 1'b0, exp_b: 8'h00, exp_err: 1'b1};
    vecs[5] = '{s: 8'h80, cout: 1'b0, a: 8'h80, c: 1'b0, exp_b: 8'h00, exp_err: 1'b0};
    vecs[6] = '{s: 8'hAB, cout: 1'b0, a: 8'h00, c: 1'b1, exp_b: 8'hAA, exp_err: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_b", 32'(b), 32'd0);
`ifdef ADDER8_RECOVER_ERR_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      do_item($sformatf("vec%0d", i), vecs[i].s, vecs[i].cout, vecs[i].a, vecs[i].c,
              vecs[i].exp_b, vecs[i].exp_err, 0);
    end

    // Backpressure: five cycles of out_ready low in DONE.
    do_item("bp", 8'h46, 1'b0, 8'h12, 1'b0, 8'h34, 1'b0, 5);

    // Reset during the 4th RUN cycle aborts the item.
    send(8'h46, 1'b0, 8'h12, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    check("aborted_no_valid", 32'(seen_valid), 32'd0);
    check("aborted_in_ready", 32'(in_ready), 32'd1);
    do_item("post_rst", 8'h10, 1'b0, 8'h0F, 1'b0, 8'h01, 1'b0, 0);

    // Random sweep through the forward adder: err must stay 0.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_item("adder_sweep", sum[W-1:0], sum[W], ra, rc, rb, 1'b0, int'($urandom_range(0, 2)));
    end

    // Random arbitrary sums against the arithmetic reference (both err polarities).
    for (int i = 0; i < 30; i++) begin
      rs = W'($urandom); ra = W'($urandom); rc = 1'($urandom); rco = 1'($urandom);
      m = ref_model(rs, rco, ra, rc);
      do_item("ref_sweep", rs, rco, ra, rc, m[W-1:0], m[W], int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
